// File: rtl/vec_pkg.sv
// Shared definitions for the vector sequencer, vector register file and decoder:
// sequencer state encoding, default geometry and derived index widths.
package vec_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } vec_state_t;

  localparam int unsigned NELEM_DEF = 4;
  localparam int unsigned NVREG_DEF = 8;

  // Index width that never collapses to zero bits for single-entry arrays.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

  localparam int unsigned VRW_DEF = clog2_min1(NVREG_DEF);
  localparam int unsigned EW_DEF  = clog2_min1(NELEM_DEF);
  localparam int unsigned LW_DEF  = $clog2(NELEM_DEF + 1);

endpackage

// File: rtl/vec_sequencer_elem_counter.sv
// Loadable element index counter; holds at len-1 and flags it as terminal count.
module elem_counter #(
  parameter int unsigned EW = 2,
  parameter int unsigned LW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          en,
  input  logic [LW-1:0] len_in,
  output logic [EW-1:0] elem,
  output logic          tc
);

  logic [LW-1:0] len_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      elem  <= '0;
      len_q <= '0;
    end else if (load) begin
      elem  <= '0;
      len_q <= len_in;
    end else if (en && !tc) begin
      elem <= elem + 1'b1;
    end
  end

  assign tc = (LW'(elem) == (len_q - 1'b1));

endmodule

// File: rtl/vec_sequencer.sv
// Multi-cycle vector op controller: stalls the PC and walks one element per cycle
// through the shared ALU, addressing the vector register file from captured operands.
module vec_sequencer
  import vec_pkg::*;
#(
  parameter int unsigned NELEM = NELEM_DEF,
  parameter int unsigned NVREG = NVREG_DEF,
  parameter int unsigned VRW   = clog2_min1(NVREG),
  parameter int unsigned EW    = clog2_min1(NELEM),
  parameter int unsigned LW    = $clog2(NELEM + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [LW-1:0]  vlen,
  input  logic [VRW-1:0] vd,
  input  logic [VRW-1:0] vn,
  input  logic [VRW-1:0] vm,
  output logic           stall,
  output logic           busy,
  output logic           done,
  output logic [VRW-1:0] vrf_ra1,
  output logic [VRW-1:0] vrf_ra2,
  output logic [VRW-1:0] vrf_wa,
  output logic [EW-1:0]  vrf_elem,
  output logic           vrf_we
);

  localparam logic [LW-1:0] NELEM_L = LW'(NELEM);

  vec_state_t     state;
  logic [VRW-1:0] vd_q;
  logic [VRW-1:0] vn_q;
  logic [VRW-1:0] vm_q;
  logic           accept;
  logic [LW-1:0]  len_clamped;
  logic [EW-1:0]  elem;
  logic           tc;

  assign accept      = (state == S_IDLE) && start && (vlen != '0);
  assign len_clamped = (vlen > NELEM_L) ? NELEM_L : vlen;

  elem_counter #(
    .EW(EW),
    .LW(LW)
  ) u_elem_counter (
    .clk    (clk),
    .reset  (reset),
    .load   (accept),
    .en     (state == S_RUN),
    .len_in (len_clamped),
    .elem   (elem),
    .tc     (tc)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
      vd_q  <= '0;
      vn_q  <= '0;
      vm_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            vd_q  <= vd;
            vn_q  <= vn;
            vm_q  <= vm;
            state <= S_RUN;
          end
        end
        S_RUN:   if (tc) state <= S_DONE;
        // start is still asserted by the same instruction here and must be ignored.
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Gating with reset suppresses the write (and stall) in the cycle a reset lands.
  assign busy     = reset && (state == S_RUN);
  assign done     = reset && (state == S_DONE);
  assign vrf_we   = busy;
  assign stall    = reset && (accept || (state == S_RUN));
  assign vrf_elem = elem;
  assign vrf_wa   = vd_q;
  assign vrf_ra1  = vn_q;
  assign vrf_ra2  = vm_q;

endmodule

// File: tb/tb_vec_sequencer.sv
// Randomized check of vec_sequencer against a cycle-schedule model of the op timeline,
// plus directed scenarios pinned with hand-computed expectations.
module tb_vec_sequencer;

  localparam int NELEM = 4;
  localparam int MAXC  = 4096;

  logic       clk;
  logic       reset;
  logic       start;
  logic [2:0] vlen;
  logic [2:0] vd;
  logic [2:0] vn;
  logic [2:0] vm;
  logic       stall;
  logic       busy;
  logic       done;
  logic [2:0] vrf_ra1;
  logic [2:0] vrf_ra2;
  logic [2:0] vrf_wa;
  logic [1:0] vrf_elem;
  logic       vrf_we;

  vec_sequencer #(
    .NELEM(4),
    .NVREG(8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .vlen     (vlen),
    .vd       (vd),
    .vn       (vn),
    .vm       (vm),
    .stall    (stall),
    .busy     (busy),
    .done     (done),
    .vrf_ra1  (vrf_ra1),
    .vrf_ra2  (vrf_ra2),
    .vrf_wa   (vrf_wa),
    .vrf_elem (vrf_elem),
    .vrf_we   (vrf_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Expected outputs per absolute cycle, filled in whenever an op is accepted.
  int e_stall[MAXC];
  int e_we[MAXC];
  int e_done[MAXC];
  int e_elem[MAXC];
  int e_wa[MAXC];
  int e_ra1[MAXC];
  int e_ra2[MAXC];
  int free_from = 0;

  int s_stall, s_busy, s_done, s_we, s_elem, s_wa, s_ra1, s_ra2;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic clear_from(input int c);
    for (int i = c; i < MAXC; i++) begin
      e_stall[i] = 0; e_we[i] = 0; e_done[i] = 0;
      e_elem[i]  = 0; e_wa[i] = 0; e_ra1[i] = 0; e_ra2[i] = 0;
    end
  endtask

  // An op accepted at cycle c with length N occupies c..c+N+1: stall c..c+N,
  // element k written at c+1+k, done at c+N+1; the next op may start at c+N+2.
  task automatic model_step(input int c);
    int n;
    if (!reset) begin
      clear_from(c);
      free_from = c + 1;
    end else if (c >= free_from && start && vlen != 0) begin
      n = (int'(vlen) > NELEM) ? NELEM : int'(vlen);
      e_stall[c] = 1;
      for (int k = 0; k < n; k++) begin
        if (c + 1 + k < MAXC) begin
          e_stall[c+1+k] = 1;
          e_we[c+1+k]    = 1;
          e_elem[c+1+k]  = k;
          e_wa[c+1+k]    = int'(vd);
          e_ra1[c+1+k]   = int'(vn);
          e_ra2[c+1+k]   = int'(vm);
        end
      end
      if (c + n + 1 < MAXC) e_done[c+n+1] = 1;
      free_from = c + n + 2;
    end
  endtask

  task automatic compare(input int c);
    s_stall = int'(stall); s_busy = int'(busy); s_done = int'(done);
    s_we = int'(vrf_we);   s_elem = int'(vrf_elem);
    s_wa = int'(vrf_wa);   s_ra1 = int'(vrf_ra1); s_ra2 = int'(vrf_ra2);
    chk("stall", s_stall, e_stall[c]);
    chk("busy", s_busy, e_we[c]);
    chk("done", s_done, e_done[c]);
    chk("vrf_we", s_we, e_we[c]);
    if (e_we[c] != 0) begin
      chk("vrf_elem", s_elem, e_elem[c]);
      chk("vrf_wa", s_wa, e_wa[c]);
      chk("vrf_ra1", s_ra1, e_ra1[c]);
      chk("vrf_ra2", s_ra2, e_ra2[c]);
    end
  endtask

  task automatic tick(input logic r, input logic st, input logic [2:0] vl,
                      input logic [2:0] d, input logic [2:0] a, input logic [2:0] b);
    reset = r; start = st; vlen = vl; vd = d; vn = a; vm = b;
    model_step(cyc);
    #3;
    compare(cyc);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  int writes;
  int done_at;

  initial begin
    clear_from(0);
    reset = 1'b0; start = 1'b0; vlen = '0; vd = '0; vn = '0; vm = '0;

    // 1: reset held with a vector op presented
    tick(1'b0, 1'b1, 3'd4, 3'd1, 3'd2, 3'd3);
    tick(1'b0, 1'b1, 3'd4, 3'd1, 3'd2, 3'd3);
    chk("rst_stall", s_stall, 0);
    chk("rst_we", s_we, 0);
    chk("rst_done", s_done, 0);
    tick(1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0);

    // 2: vlen=4, operands change after capture
    tick(1'b1, 1'b1, 3'd4, 3'd1, 3'd2, 3'd3);
    chk("t2_capture_stall", s_stall, 1);
    chk("t2_capture_we", s_we, 0);
    for (int k = 0; k < 4; k++) begin
      tick(1'b1, 1'b1, 3'd4, 3'd6, 3'd5, 3'd4);
      chk("t2_we", s_we, 1);
      chk("t2_elem", s_elem, k);
      chk("t2_wa", s_wa, 1);
      chk("t2_ra1", s_ra1, 2);
      chk("t2_ra2", s_ra2, 3);
      chk("t2_no_done", s_done, 0);
    end
    tick(1'b1, 1'b1, 3'd4, 3'd1, 3'd2, 3'd3);
    chk("t2_done", s_done, 1);
    chk("t2_done_stall", s_stall, 0);
    tick(1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0);
    chk("t2_idle_done", s_done, 0);

    // 3: vlen=0 is a NOP
    tick(1'b1, 1'b1, 3'd0, 3'd2, 3'd2, 3'd2);
    chk("t3_stall", s_stall, 0);
    chk("t3_we", s_we, 0);
    chk("t3_done", s_done, 0);
    tick(1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0);
    chk("t3_busy", s_busy, 0);

    // 4: vlen=7 clamps to 4 elements, done at T+5
    tick(1'b1, 1'b1, 3'd7, 3'd7, 3'd0, 3'd7);
    writes = 0; done_at = -1;
    for (int j = 1; j <= 5; j++) begin
      tick(1'b1, 1'b1, 3'd7, 3'd7, 3'd0, 3'd7);
      if (s_we != 0) writes++;
      if (s_done != 0) done_at = j;
    end
    chk("t4_writes", writes, 4);
    chk("t4_done_at", done_at, 5);
    tick(1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0);

    // 5: reset lands while element 2 would be written
    tick(1'b1, 1'b1, 3'd4, 3'd5, 3'd5, 3'd1);
    writes = 0;
    tick(1'b1, 1'b1, 3'd4, 3'd5, 3'd5, 3'd1);
    if (s_we != 0) writes++;
    tick(1'b1, 1'b1, 3'd4, 3'd5, 3'd5, 3'd1);
    if (s_we != 0) writes++;
    chk("t5_last_elem", s_elem, 1);
    tick(1'b0, 1'b1, 3'd4, 3'd5, 3'd5, 3'd1);
    chk("t5_rst_we", s_we, 0);
    chk("t5_rst_stall", s_stall, 0);
    chk("t5_writes", writes, 2);
    tick(1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0);
    chk("t5_after_busy", s_busy, 0);
    chk("t5_after_stall", s_stall, 0);

    // 6: start held through DONE gives back-to-back ops
    tick(1'b1, 1'b1, 3'd2, 3'd3, 3'd4, 3'd5);
    tick(1'b1, 1'b1, 3'd2, 3'd3, 3'd4, 3'd5);
    tick(1'b1, 1'b1, 3'd2, 3'd3, 3'd4, 3'd5);
    tick(1'b1, 1'b1, 3'd2, 3'd3, 3'd4, 3'd5);
    chk("t6_done", s_done, 1);
    chk("t6_done_stall", s_stall, 0);
    chk("t6_done_we", s_we, 0);
    tick(1'b1, 1'b1, 3'd2, 3'd3, 3'd4, 3'd5);
    chk("t6_restart_stall", s_stall, 1);
    chk("t6_restart_busy", s_busy, 0);
    tick(1'b1, 1'b1, 3'd2, 3'd3, 3'd4, 3'd5);
    chk("t6_second_we", s_we, 1);
    chk("t6_second_elem", s_elem, 0);
    tick(1'b1, 1'b1, 3'd2, 3'd3, 3'd4, 3'd5);
    tick(1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0);
    chk("t6_second_done", s_done, 1);
    tick(1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0);

    // Randomized traffic including occasional resets and NOPs
    for (int i = 0; i < 2000; i++) begin
      tick(($urandom_range(0, 49) != 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0,
           3'($urandom_range(0, 7)),
           3'($urandom_range(0, 7)),
           3'($urandom_range(0, 7)),
           3'($urandom_range(0, 7)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
